// File: rtl/mii_udp_tx_gen.sv
// mii_udp_tx_gen: UDP/IPv4 Ethernet II frame generator that drives an MII transmit interface.
// Sends preamble/SFD, MAC/IPv4/UDP headers, a payload read from a FIFO, zero padding,
// an optional FCS and the inter-frame gap. The IPv4 checksum is computed while the preamble is sent.
// Ports: mii_tx_clk (only clock), rst (async, active high), start/pay_len (frame request and length),
//   pay_rd/pay_data (payload FIFO; data is valid the cycle after pay_rd), busy/done (frame status),
//   mii_tx_en/mii_tx_er/mii_tx_da (MII transmit, low nibble of each byte first).
// Define UDP_TX_GEN_FCS_EN to append a CRC-32 FCS; otherwise the MAC/PHY must append it.
module mii_udp_tx_gen #(
  parameter logic [47:0] DST_MAC = 48'hFF_FF_FF_FF_FF_FF,
  parameter logic [47:0] SRC_MAC = 48'h00_0A_35_01_FE_C0,
  parameter logic [31:0] SRC_IP = 32'hC0A8_0002,
  parameter logic [31:0] DST_IP = 32'hC0A8_0003,
  parameter logic [15:0] SRC_PORT = 16'd5000,
  parameter logic [15:0] DST_PORT = 16'd6000,
  parameter int MAX_LEN = 1472,
  parameter int IFG_BYTES = 12
) (
  input  logic        mii_tx_clk,
  input  logic        rst,
  input  logic        start,
  input  logic [10:0] pay_len,
  output logic        pay_rd,
  input  logic [7:0]  pay_data,
  output logic        busy,
  output logic        done,
  output logic        mii_tx_en,
  output logic        mii_tx_er,
  output logic [3:0]  mii_tx_da
);
  typedef enum logic [3:0] {IDLE, PRE, ETH, IPH, UDPH, PAY, PAD, FCS, IFG} state_t;
`ifdef UDP_TX_GEN_FCS_EN
  localparam state_t TAIL = FCS;
  logic [31:0] crc, crc_inv;
  function automatic logic [31:0] crc4(input logic [31:0] c, input logic [3:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 4; i++) r = (r[0] ^ d[i]) ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
    return r;
  endfunction
`else
  localparam state_t TAIL = IFG;
`endif
  state_t st, st_n, succ;
  logic [10:0] cnt, cnt_n, last, len;
  logic ph, ph_n;
  logic [15:0] id, acc, tot_len, udp_len;
  logic [16:0] acc_sum;
  logic [3:0] wk, wsel;
  logic [143:0] cw;
  logic [335:0] hdr;
  logic [5:0] hidx, hoff;
  logic [7:0] pay_q, byte_n;
  logic [3:0] nib_n, da_n;
  logic rd_n, done_n, en_n;
  assign mii_tx_er = 1'b0;
  // The output registers are loaded from the position the sequencer moves to, so every
  // nibble leaves a flop. Payload bytes are therefore requested one nibble earlier than
  // they are shown: the low nibble is taken straight from pay_data, the high one from pay_q.
  always_comb begin
    tot_len = 16'd28 + {5'd0, len};
    udp_len = 16'd8 + {5'd0, len};
    cw = {16'h4500, tot_len, id, 16'h4000, 16'h4011, SRC_IP, DST_IP};
    wk = {cnt[2:0], ph};
    wsel = (wk < 4'd9) ? 4'd8 - wk : 4'd0;
    acc_sum = {1'b0, acc} + {1'b0, cw[{wsel, 4'b0000} +: 16]};
    hdr = {DST_MAC, SRC_MAC, 16'h0800, 16'h4500, tot_len, id, 16'h4000, 16'h4011, ~acc,
           SRC_IP, DST_IP, SRC_PORT, DST_PORT, udp_len, 16'h0000};
    last = (st == PRE)  ? 11'd7 :
           (st == ETH)  ? 11'd13 :
           (st == IPH)  ? 11'd19 :
           (st == UDPH) ? 11'd7 :
           (st == PAY)  ? len - 11'd1 :
           (st == PAD)  ? 11'd17 - len :
           (st == FCS)  ? 11'd3 : 11'(IFG_BYTES - 1);
    succ = (st == PRE)  ? ETH :
           (st == ETH)  ? IPH :
           (st == IPH)  ? UDPH :
           (st == UDPH) ? ((len != 11'd0) ? PAY : PAD) :
           (st == PAY)  ? ((len < 11'd18) ? PAD : TAIL) :
           (st == PAD)  ? TAIL :
           (st == FCS)  ? IFG : IDLE;
    st_n = st;
    cnt_n = cnt;
    ph_n = ph;
    if (st == IDLE) begin
      st_n = start ? PRE : IDLE;
      cnt_n = '0;
      ph_n = 1'b0;
    end else if (!ph) begin
      ph_n = 1'b1;
    end else begin
      ph_n = 1'b0;
      st_n = (cnt == last) ? succ : st;
      cnt_n = (cnt == last) ? 11'd0 : cnt + 11'd1;
    end
    hidx = (st_n == ETH) ? cnt_n[5:0] : (st_n == IPH) ? cnt_n[5:0] + 6'd14 : cnt_n[5:0] + 6'd34;
    hoff = (hidx > 6'd41) ? 6'd0 : 6'd41 - hidx;
    byte_n = (st_n == PRE) ? ((cnt_n == 11'd7) ? 8'hD5 : 8'h55) :
             (st_n inside {ETH, IPH, UDPH}) ? hdr[{hoff, 3'b000} +: 8] :
             (st_n == PAY) ? (ph_n ? pay_q : pay_data) : 8'h00;
    nib_n = ph_n ? byte_n[7:4] : byte_n[3:0];
`ifdef UDP_TX_GEN_FCS_EN
    crc_inv = ~crc;
    da_n = (st_n == FCS) ? crc_inv[{cnt_n[1:0], ph_n, 2'b00} +: 4] : nib_n;
`else
    da_n = nib_n;
`endif
    en_n = (st_n != IDLE) && (st_n != IFG);
    rd_n = !ph_n && (((st_n == UDPH) && (cnt_n == 11'd7) && (len != 11'd0)) ||
                     ((st_n == PAY) && (cnt_n != len - 11'd1)));
    done_n = (st_n == IFG) && (cnt_n == 11'(IFG_BYTES - 1)) && ph_n;
  end
  always_ff @(posedge mii_tx_clk or posedge rst) begin
    if (rst) begin
      st <= IDLE;
      cnt <= '0;
      ph <= 1'b0;
      len <= '0;
      id <= '0;
      acc <= '0;
      pay_q <= '0;
      pay_rd <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      mii_tx_en <= 1'b0;
      mii_tx_da <= '0;
`ifdef UDP_TX_GEN_FCS_EN
      crc <= '1;
`endif
    end else begin
      st <= st_n;
      cnt <= cnt_n;
      ph <= ph_n;
      pay_rd <= rd_n;
      busy <= st_n != IDLE;
      done <= done_n;
      mii_tx_en <= en_n;
      mii_tx_da <= da_n;
      if (st == IDLE && start) begin
        len <= (pay_len > 11'(MAX_LEN)) ? 11'(MAX_LEN) : pay_len;
        acc <= '0;
      end
      // Ones-complement sum of the nine non-checksum header words, one word per PRE nibble.
      if (st == PRE && wk < 4'd9) acc <= acc_sum[15:0] + {15'd0, acc_sum[16]};
      if (st_n == PAY && !ph_n) pay_q <= pay_data;
      if (st == IFG && st_n == IDLE) id <= id + 16'd1;
`ifdef UDP_TX_GEN_FCS_EN
      if (st == IDLE && start) crc <= '1;
      else if (st_n inside {ETH, IPH, UDPH, PAY, PAD}) crc <= crc4(crc, nib_n);
`endif
    end
  end
endmodule

// File: tb/tb_mii_udp_tx_gen.sv
// tb_mii_udp_tx_gen: directed self-checking bench for mii_udp_tx_gen.
module tb_mii_udp_tx_gen;
`ifdef UDP_TX_GEN_FCS_EN
  localparam int F = 4;
`else
  localparam int F = 0;
`endif
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [10:0] pay_len = '0;
  logic [7:0] pay_data = '0;
  logic pay_rd, busy, done, mii_tx_en, mii_tx_er;
  logic [3:0] mii_tx_da;
  always #5 clk = ~clk;
  mii_udp_tx_gen dut (
    .mii_tx_clk(clk), .rst(rst), .start(start), .pay_len(pay_len), .pay_rd(pay_rd),
    .pay_data(pay_data), .busy(busy), .done(done), .mii_tx_en(mii_tx_en),
    .mii_tx_er(mii_tx_er), .mii_tx_da(mii_tx_da)
  );
  int tests = 0, fails = 0;
  int en_cnt, rd_cnt, done_cnt, ifg_cnt, rp, fstart;
  bit hi, rd_seen, prev_en;
  logic [3:0] lo_n;
  logic [7:0] cap[$], exp_q[$];
  logic [7:0] fifo_mem[2048];
  logic [15:0] ids[$];
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    tests++;
    assert (got === want) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, want);
    end
  endtask
  function automatic logic [15:0] w16(input int i);
    return {cap[i], cap[i+1]};
  endfunction
  task automatic tick;
    @(posedge clk);
    #1;
    if (rd_seen) begin
      pay_data = fifo_mem[rp];
      rp++;
    end
    @(negedge clk);
    rd_seen = pay_rd;
    if (mii_tx_en && !prev_en) fstart = cap.size();
    if (mii_tx_en) begin
      en_cnt++;
      if (hi) cap.push_back({mii_tx_da, lo_n});
      else lo_n = mii_tx_da;
      hi = !hi;
    end
    if (!mii_tx_en && prev_en) ids.push_back({cap[fstart+26], cap[fstart+27]});
    prev_en = mii_tx_en;
    if (pay_rd) rd_cnt++;
    if (done) done_cnt++;
    if (busy && !mii_tx_en) ifg_cnt++;
  endtask
  task automatic clear;
    en_cnt = 0; rd_cnt = 0; done_cnt = 0; ifg_cnt = 0; rp = 0; fstart = 0;
    hi = 0; rd_seen = 0; prev_en = 0;
    cap.delete(); ids.delete();
  endtask
  task automatic push_n(input logic [47:0] v, input int nb);
    for (int i = nb - 1; i >= 0; i--) exp_q.push_back(v[8*i +: 8]);
  endtask
  function automatic logic [15:0] ip_csum(input logic [15:0] tl, input logic [15:0] idv);
    logic [31:0] s;
    s = 32'h4500 + tl + idv + 32'h4000 + 32'h4011 + 32'hC0A8 + 32'h0002 + 32'hC0A8 + 32'h0003;
    s = s[15:0] + s[31:16];
    s = s[15:0] + s[31:16];
    return ~s[15:0];
  endfunction
  task automatic build(input int l, input logic [15:0] idv);
    int n, sz;
    logic [15:0] tl, ul;
    logic [31:0] c;
    n = (l > 1472) ? 1472 : l;
    tl = 16'(28 + n);
    ul = 16'(8 + n);
    exp_q.delete();
    for (int i = 0; i < 7; i++) exp_q.push_back(8'h55);
    exp_q.push_back(8'hD5);
    push_n(48'hFFFF_FFFF_FFFF, 6); push_n(48'h000A_3501_FEC0, 6); push_n(48'h0800, 2);
    push_n(48'h4500, 2); push_n({32'd0, tl}, 2); push_n({32'd0, idv}, 2);
    push_n(48'h4000, 2); push_n(48'h4011, 2); push_n({32'd0, ip_csum(tl, idv)}, 2);
    push_n(48'hC0A8_0002, 4); push_n(48'hC0A8_0003, 4);
    push_n(48'd5000, 2); push_n(48'd6000, 2); push_n({32'd0, ul}, 2); push_n(48'd0, 2);
    for (int i = 0; i < n; i++) exp_q.push_back(fifo_mem[i]);
    for (int i = n; i < 18; i++) exp_q.push_back(8'h00);
    sz = exp_q.size();
    c = 32'hFFFF_FFFF;
    for (int i = 8; i < sz; i++) begin
      c = c ^ {24'd0, exp_q[i]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    c = ~c;
    if (F == 4) for (int i = 0; i < 4; i++) exp_q.push_back(c[8*i +: 8]);
  endtask
  task automatic cmp_frame(input string tag, input bit exact);
    int mism;
    mism = 0;
    if (exact) chk({tag, " length"}, cap.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) if (cap[i] !== exp_q[i]) mism++;
    chk({tag, " byte mismatches"}, mism, 0);
  endtask
  task automatic run_frame(input string tag, input int l, input logic [15:0] idv);
    int n;
    clear;
    pay_len = 11'(l);
    start = 1'b1;
    tick;
    chk({tag, " busy@1"}, busy, 1);
    chk({tag, " tx_en@1"}, mii_tx_en, 1);
    chk({tag, " da@1"}, mii_tx_da, 4'h5);
    start = 1'b0;
    for (int k = 0; k < 5000 && done_cnt == 0; k++) tick;
    chk({tag, " done pulse"}, done_cnt, 1);
    tick;
    chk({tag, " busy fall"}, busy, 0);
    n = (l > 1472) ? 1472 : l;
    build(l, idv);
    cmp_frame(tag, 1'b1);
    chk({tag, " tx_en cycles"}, en_cnt, 2 * (50 + ((n < 18) ? 18 : n) + F));
    chk({tag, " pay_rd pulses"}, rd_cnt, n);
    chk({tag, " ifg cycles"}, ifg_cnt, 24);
  endtask
  initial begin
    for (int i = 0; i < 2048; i++) fifo_mem[i] = 8'(i);
    clear;
    tick;
    chk("rst pay_rd", pay_rd, 0);
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst tx_en", mii_tx_en, 0);
    chk("rst tx_da", mii_tx_da, 0);
    chk("tx_er", mii_tx_er, 0);
    rst = 1'b0;
    tick;
    tick;
    run_frame("len18", 18, 16'd0);
    chk("len18 tx_en 136/144", en_cnt, (F == 4) ? 144 : 136);
    chk("len18 ethertype", w16(20), 16'h0800);
    chk("len18 ip total", w16(24), 16'h002E);
    chk("len18 ip id", w16(26), 16'h0000);
    chk("len18 ip csum", w16(32), 16'hB969);
    chk("len18 udp len", w16(46), 16'h001A);
    chk("len18 last payload", cap[67], 8'h11);
    run_frame("len0", 0, 16'd1);
    chk("len0 pay_rd", rd_cnt, 0);
    chk("len0 ip total", w16(24), 16'h001C);
    chk("len0 ip id", w16(26), 16'h0001);
    chk("len0 ip csum", w16(32), 16'hB97A);
    chk("len0 udp len", w16(46), 16'h0008);
    chk("len0 pad last", cap[67], 8'h00);
    run_frame("len100", 100, 16'd2);
    chk("len100 pay_rd", rd_cnt, 100);
    chk("len100 tx_en 300/308", en_cnt, (F == 4) ? 308 : 300);
    run_frame("len2000", 2000, 16'd3);
    chk("len2000 pay_rd", rd_cnt, 1472);
    chk("len2000 udp len", w16(46), 16'd1480);
    chk("len2000 ip total", w16(24), 16'd1500);
    clear;
    pay_len = 11'd100;
    start = 1'b1;
    tick;
    start = 1'b0;
    for (int k = 0; k < 1000 && rd_cnt < 50; k++) tick;
    chk("abort reached 50 reads", rd_cnt, 50);
    #2 rst = 1'b1;
    #1;
    chk("abort tx_en", mii_tx_en, 0);
    chk("abort busy", busy, 0);
    chk("abort tx_da", mii_tx_da, 0);
    chk("abort pay_rd", pay_rd, 0);
    tick;
    tick;
    rst = 1'b0;
    tick;
    clear;
    pay_len = 11'd20;
    start = 1'b1;
    for (int k = 0; k < 3000 && done_cnt < 3; k++) tick;
    start = 1'b0;
    tick;
    chk("held done pulses", done_cnt, 3);
    chk("held busy idle", busy, 0);
    chk("held frames", ids.size(), 3);
    chk("held id0", ids[0], 16'd0);
    chk("held id1", ids[1], 16'd1);
    chk("held id2", ids[2], 16'd2);
    chk("held ifg cycles", ifg_cnt, 72);
    chk("held tx_en cycles", en_cnt, 3 * 2 * (70 + F));
    build(20, 16'd0);
    cmp_frame("held first frame", 1'b0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
